// File: rtl/gc_pkg.sv
// Shared types and constants for the garbled-table packer: table entry layout,
// per-table beat count and serializer states.
package gc_pkg;

    localparam int NR_AES   = 10;
    localparam int GC_K     = 128;
    localparam int GC_S     = 20;
    localparam int GC_W     = 64;
    localparam int GC_DEPTH = 8;

    localparam int GC_BEATS = 2 * GC_K / GC_W;

    // FIFO entry layout, most-significant field first
    typedef struct packed {
        logic [GC_S-1:0] gid;
        logic [GC_K-1:0] t0;
        logic [GC_K-1:0] t1;
    } gc_table_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } gc_state_t;

    function automatic int gc_beats(input int k, input int w);
        return 2 * k / w;
    endfunction

endpackage

// File: rtl/gc_sync_fifo.sv
// Single-clock FIFO with registered pointers and occupancy count.
// A push while full is accepted only when a pop completes in the same cycle.
module gc_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr;
    logic             rd;

    assign full  = count == (AW + 1)'(DEPTH);
    assign empty = count == '0;
    assign rd    = pop && !empty;
    assign wr    = push && (!full || rd);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + 1'b1;
            if (rd) rd_ptr <= rd_ptr + 1'b1;
            case ({wr, rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/gc_table_packer.sv
// Captures garbled tables LAT cycles after issue, queues them and serializes
// them onto a W-bit valid/ready stream. Define GC_PACK_HDR_EN for a gid header beat.
module gc_table_packer
    import gc_pkg::*;
#(
    parameter int K     = GC_K,
    parameter int S     = GC_S,
    parameter int LAT   = NR_AES,
    parameter int W     = GC_W,
    parameter int DEPTH = GC_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         issue_vld,
    input  logic [S-1:0] issue_gid,
    input  logic [K-1:0] t0,
    input  logic [K-1:0] t1,
    output logic [W-1:0] m_data,
    output logic [S-1:0] m_gid,
    output logic         m_valid,
    input  logic         m_ready,
    output logic         m_last,
    output logic         credit_zero,
    output logic         overflow
);

`ifdef GC_PACK_HDR_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif
    localparam int TOTAL = gc_beats(K, W) + HDR;
    localparam int BW    = $clog2(TOTAL + 1);
    localparam int IW    = $clog2(LAT + 1);
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int EW    = S + 2 * K;

    logic [LAT-1:0] vld_dl;
    logic [S-1:0]   gid_dl [LAT];
    logic [IW-1:0]  inflight;
    logic           tap_vld;
    logic [S-1:0]   tap_gid;

    assign tap_vld = vld_dl[LAT-1];
    assign tap_gid = gid_dl[LAT-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_dl   <= '0;
            inflight <= '0;
        end else begin
            vld_dl[0] <= issue_vld;
            for (int i = 1; i < LAT; i++) vld_dl[i] <= vld_dl[i-1];
            if (issue_vld && !tap_vld)      inflight <= inflight + 1'b1;
            else if (!issue_vld && tap_vld) inflight <= inflight - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        gid_dl[0] <= issue_gid;
        for (int i = 1; i < LAT; i++) gid_dl[i] <= gid_dl[i-1];
    end

    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [EW-1:0] head;
    logic          pop;
    logic          push_ok;

    assign push_ok = tap_vld && (!fifo_full || pop);

    gc_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tap_vld),
        .pop   (pop),
        .din   ({tap_gid, t0, t1}),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      overflow <= 1'b0;
        else if (tap_vld && !push_ok) overflow <= 1'b1;
    end

    // >= rather than ==: a scheduler ignoring credit can push the sum past DEPTH
    assign credit_zero = (32'(fifo_count) + 32'(inflight)) >= 32'(DEPTH);

    gc_state_t     state;
    gc_state_t     state_n;
    logic [BW-1:0] beat;
    logic [BW-1:0] beat_n;
    logic          final_beat;

    assign m_valid    = state == SEND;
    assign final_beat = m_valid && beat == BW'(TOTAL - 1);
    assign pop        = final_beat && m_ready;
    assign m_last     = final_beat;

    always_comb begin
        state_n = state;
        beat_n  = beat;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_n = SEND;
                    beat_n  = '0;
                end
            end
            SEND: begin
                if (m_ready) begin
                    if (final_beat) begin
                        beat_n = '0;
                        // the popped entry was the last one and nothing lands this cycle
                        if (fifo_count == CW'(1) && !push_ok) state_n = IDLE;
                    end else begin
                        beat_n = beat + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            beat  <= '0;
        end else begin
            state <= state_n;
            beat  <= beat_n;
        end
    end

    logic [2*K-1:0] rows;
    logic [S-1:0]   head_gid;
    logic [BW-1:0]  dbeat;
    logic [W-1:0]   beat_data;

    assign head_gid = head[EW-1 -: S];
    assign rows     = {head[K-1:0], head[2*K-1:K]};  // t1 above t0, so beats walk upward

    always_comb begin
        if (HDR != 0 && beat == '0) dbeat = '0;
        else                        dbeat = beat - BW'(HDR);
        beat_data = W'(rows >> (dbeat * W));
        if (HDR != 0 && beat == '0) beat_data = W'(head_gid);
    end

    assign m_data = m_valid ? beat_data : '0;
    assign m_gid  = m_valid ? head_gid : '0;

endmodule
